// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, persistent PSR flags and a multi-cycle shift-add multiplier.
// Flags are {C,L,F,Z,N}; ADDC/SUBC consume the stored carry.
//
// state    | meaning
// IDLE     | waiting for an operation, in_ready=1
// MUL_BUSY | shift-add multiply in progress, one partial product per cycle
// DONE     | result/flags/out_err valid, held until out_ready
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 8,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags,
  output logic             out_err
);

  localparam int FC = 4;
  localparam int FL = 3;
  localparam int FF = 2;
  localparam int FZ = 1;
  localparam int FN = 0;

  localparam logic [SHW:0]   WLIM     = (SHW+1)'(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, MUL_BUSY, DONE} state_t;

  typedef enum logic [3:0] {
    K_AND, K_OR, K_XOR, K_ADD, K_ADDU, K_ADDC, K_SUB, K_SUBC,
    K_CMP, K_MOV, K_LUI, K_SHIFT, K_MUL, K_BAD
  } kind_t;

  state_t             state;
  kind_t              kind;
  logic [WIDTH-1:0]   bx;
  logic [WIDTH-1:0]   imm_s;
  logic [WIDTH-1:0]   imm_z;
  logic [WIDTH-1:0]   lui_val;
  logic               sh_reg;
  logic               sh_arith;
  logic               sh_left;
  logic [SHW:0]       sh_mag;
  logic [SHW:0]       samt;
  logic               cin;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic               ltu;
  logic               lts;
  logic               add_ovf;
  logic               sub_ovf;
  logic [WIDTH-1:0]   d_result;
  logic [4:0]         d_flags;
  logic               d_err;
  logic               d_mul;
  logic               accept;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;

  function automatic logic [WIDTH-1:0] do_shift(input logic [WIDTH-1:0] v,
                                                input logic [SHW:0]     mag,
                                                input logic             left,
                                                input logic             arith);
    logic big;
    big = (mag >= WLIM);
    if (left)
      do_shift = big ? '0 : (v << mag);
    else if (arith)
      do_shift = big ? {WIDTH{v[WIDTH-1]}} : WIDTH'($signed(v) >>> mag);
    else
      do_shift = big ? '0 : (v >> mag);
  endfunction

  assign imm_s   = {{(WIDTH-IMM_W){b[IMM_W-1]}}, b[IMM_W-1:0]};
  assign imm_z   = {{(WIDTH-IMM_W){1'b0}}, b[IMM_W-1:0]};
  assign lui_val = {b[IMM_W-1:0], {(WIDTH-IMM_W){1'b0}}};

  // Opcode decode: upper nibble 0000 is register form, other nibbles carry an immediate in b.
  always_comb begin
    kind     = K_BAD;
    bx       = b;
    sh_reg   = 1'b0;
    sh_arith = 1'b0;
    casez (opcode)
      8'b0000_0001: kind = K_AND;
      8'b0000_0010: kind = K_OR;
      8'b0000_0011: kind = K_XOR;
      8'b0000_0101: kind = K_ADD;
      8'b0000_0110: kind = K_ADDU;
      8'b0000_0111: kind = K_ADDC;
      8'b0000_1001: kind = K_SUB;
      8'b0000_1010: kind = K_SUBC;
      8'b0000_1011: kind = K_CMP;
      8'b0000_1101: kind = K_MOV;
      8'b0000_1110: kind = K_MUL;
      8'b0001_????: begin kind = K_AND;  bx = imm_z; end
      8'b0010_????: begin kind = K_OR;   bx = imm_z; end
      8'b0011_????: begin kind = K_XOR;  bx = imm_z; end
      8'b0101_????: begin kind = K_ADD;  bx = imm_s; end
      8'b0110_????: begin kind = K_ADDU; bx = imm_s; end
      8'b0111_????: begin kind = K_ADDC; bx = imm_s; end
      8'b1001_????: begin kind = K_SUB;  bx = imm_s; end
      8'b1010_????: begin kind = K_SUBC; bx = imm_s; end
      8'b1011_????: begin kind = K_CMP;  bx = imm_s; end
      8'b1101_????: begin kind = K_MOV;  bx = imm_z; end
      8'b1111_????: kind = K_LUI;
      8'b1000_0100: begin kind = K_SHIFT; sh_reg = 1'b1; end
      8'b1000_0110: begin kind = K_SHIFT; sh_reg = 1'b1; sh_arith = 1'b1; end
      8'b1000_000?: kind = K_SHIFT;
      8'b1000_001?: begin kind = K_SHIFT; sh_arith = 1'b1; end
      default:      kind = K_BAD;
    endcase
  end

  // Register-form shifts take a signed amount; immediate forms take direction from opcode[0].
  always_comb begin
    samt = b[SHW:0];
    if (sh_reg) begin
      sh_left = ~samt[SHW];
      sh_mag  = samt[SHW] ? -samt : samt;
    end else begin
      sh_left = ~opcode[0];
      sh_mag  = {1'b0, b[SHW-1:0]};
    end
  end

  assign cin     = ((kind == K_ADDC) || (kind == K_SUBC)) ? flags[FC] : 1'b0;
  assign sum     = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
  assign diff    = {1'b0, a} - {1'b0, bx} - {{WIDTH{1'b0}}, cin};
  assign ltu     = (a < bx);
  assign lts     = ($signed(a) < $signed(bx));
  assign add_ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != bx[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    d_result = '0;
    d_flags  = flags;
    d_err    = 1'b0;
    case (kind)
      K_AND: begin d_result = a & bx; d_flags[FZ] = ~|(a & bx); end
      K_OR:  begin d_result = a | bx; d_flags[FZ] = ~|(a | bx); end
      K_XOR: begin d_result = a ^ bx; d_flags[FZ] = ~|(a ^ bx); end
      K_ADD, K_ADDC: begin
        d_result    = sum[WIDTH-1:0];
        d_flags[FC] = sum[WIDTH];
        d_flags[FF] = add_ovf;
        d_flags[FZ] = ~|sum[WIDTH-1:0];
      end
      K_ADDU: d_result = sum[WIDTH-1:0];
      K_SUB, K_SUBC: begin
        d_result    = diff[WIDTH-1:0];
        d_flags[FC] = diff[WIDTH];
        d_flags[FF] = sub_ovf;
        d_flags[FZ] = ~|diff[WIDTH-1:0];
        d_flags[FL] = ltu;
        d_flags[FN] = lts;
      end
      K_CMP: begin
        d_flags[FZ] = (a == bx);
        d_flags[FL] = ltu;
        d_flags[FN] = lts;
      end
      K_MOV:   d_result = bx;
      K_LUI:   d_result = lui_val;
      K_SHIFT: d_result = do_shift(a, sh_mag, sh_left, sh_arith);
      K_MUL:   d_result = '0;
      default: d_err = 1'b1;
    endcase
  end

  assign d_mul    = (kind == K_MUL);
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      out_err   <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else if (accept) begin
      if (d_mul) begin
        state     <= MUL_BUSY;
        out_valid <= 1'b0;
        mcand     <= {{WIDTH{1'b0}}, a};
        mplier    <= b;
        acc       <= '0;
        cnt       <= CNT_LAST;
      end else begin
        state     <= DONE;
        out_valid <= 1'b1;
        result    <= d_result;
        flags     <= d_flags;
        out_err   <= d_err;
      end
    end else begin
      case (state)
        MUL_BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          // Last partial product folds straight into the result register.
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= acc_nxt[WIDTH-1:0];
            flags     <= {|acc_nxt[2*WIDTH-1:WIDTH], flags[FL], flags[FF],
                          ~|acc_nxt[WIDTH-1:0], flags[FN]};
            out_err   <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expectations are queued when an op is driven and popped when out_valid is seen.
module tb_alu_seq;

  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_SUBC = 8'h0A;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_MOV  = 8'h0D;
  localparam logic [7:0] OP_MUL  = 8'h0E;
  localparam logic [7:0] OP_ORI  = 8'h20;
  localparam logic [7:0] OP_ADDI = 8'h50;
  localparam logic [7:0] OP_CMPI = 8'hB0;
  localparam logic [7:0] OP_MOVI = 8'hD0;
  localparam logic [7:0] OP_LUI  = 8'hF0;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_ASHU = 8'h86;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  opcode = 8'h00;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] result;
  logic [4:0]  flags;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] res;
    logic [4:0]  fl;
    logic        err;
  } exp_t;

  exp_t       sbq[$];
  logic [4:0] psr = 5'b00000;

  alu_seq #(.WIDTH(16), .IMM_W(8), .SHW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [15:0] r, input logic [4:0] f, input logic e);
    exp_t x;
    x.res = r; x.fl = f; x.err = e;
    sbq.push_back(x);
    psr = f;
  endtask

  // Returns #1 after the accepting edge with in_valid dropped.
  task automatic send(input logic [7:0] op, input logic [15:0] av, input logic [15:0] bv,
                      output bit ok);
    bit r;
    int n;
    opcode = op; a = av; b = bv; in_valid = 1'b1;
    r = 1'b0; n = 0;
    while (!r && n < 100) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    ok = r;
  endtask

  task automatic wait_out(input int limit, output int cyc);
    cyc = 1;
    while (!out_valid && cyc < limit) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if (result !== 16'h0000 || flags !== 5'b00000 || out_valid !== 1'b0 ||
        out_err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: result=%h flags=%b ov=%b err=%b rdy=%b, want 0000 00000 0 0 1",
               result, flags, out_valid, out_err, in_ready);
    end
  endtask

  task automatic test_add_sub_flags;
    bit ok; int cyc; exp_t e;
    push(16'hFFFE, 5'b11001, 1'b0);
    send(OP_SUB, 16'h0003, 16'h0005, ok);
    wait_out(10, cyc);
    e = sbq.pop_front();
    checks++;
    if (!ok || !out_valid || result !== e.res || flags !== e.fl || out_err !== e.err) begin
      errors++;
      $display("FAIL sub: result=%h flags=%b err=%b, want %h %b %b", result, flags, out_err, e.res, e.fl, e.err);
    end
    push(16'h8000, 5'b01101, 1'b0);
    send(OP_ADD, 16'h7FFF, 16'h0001, ok);
    wait_out(10, cyc);
    e = sbq.pop_front();
    checks++;
    if (!ok || cyc !== 1 || result !== e.res || flags !== e.fl || out_err !== e.err) begin
      errors++;
      $display("FAIL add_ovf: result=%h flags=%b cyc=%0d, want %h %b 1", result, flags, cyc, e.res, e.fl);
    end
  endtask

  task automatic test_back_to_back;
    bit ok; int cyc; exp_t e;
    @(negedge clk);
    push(16'hFFFE, 5'b11001, 1'b0);
    send(OP_SUB, 16'h0003, 16'h0005, ok);
    e = sbq.pop_front();
    checks++;
    if (!ok || !out_valid || result !== e.res || flags !== e.fl) begin
      errors++;
      $display("FAIL b2b_sub: result=%h flags=%b, want %h %b", result, flags, e.res, e.fl);
    end
    push(16'hFFFF, 5'b10000, 1'b0);
    send(OP_SUBC, 16'h0000, 16'h0000, ok);
    e = sbq.pop_front();
    checks++;
    if (!ok || !out_valid || result !== e.res || flags !== e.fl) begin
      errors++;
      $display("FAIL b2b_subc: result=%h flags=%b, want %h %b", result, flags, e.res, e.fl);
    end
  endtask

  task automatic test_cmpi;
    bit ok; int cyc; exp_t e;
    push(16'h0000, {psr[4], 1'b0, psr[2], 1'b1, 1'b0}, 1'b0);
    send(OP_CMPI, 16'hFFFF, 16'h00FF, ok);
    wait_out(10, cyc);
    e = sbq.pop_front();
    checks++;
    if (!ok || result !== e.res || flags !== e.fl || out_err !== 1'b0) begin
      errors++;
      $display("FAIL cmpi: result=%h flags=%b, want %h %b", result, flags, e.res, e.fl);
    end
  endtask

  task automatic test_misc_ops;
    logic [7:0]  ops [5] = '{OP_ORI, OP_XOR, OP_LUI, OP_MOVI, OP_ADDI};
    logic [15:0] av  [5] = '{16'h1200, 16'h5A5A, 16'h1234, 16'h9999, 16'h0005};
    logic [15:0] bv  [5] = '{16'hFF80, 16'h5A5A, 16'h00AB, 16'h12F0, 16'h00FF};
    logic [15:0] rv  [5] = '{16'h1280, 16'h0000, 16'hAB00, 16'h00F0, 16'h0004};
    bit ok; int cyc; exp_t e; logic [4:0] f;
    for (int i = 0; i < 5; i++) begin
      f = psr;
      case (i)
        0: f[1] = 1'b0;
        1: f[1] = 1'b1;
        4: begin f[4] = 1'b1; f[2] = 1'b0; f[1] = 1'b0; end
        default: ;
      endcase
      push(rv[i], f, 1'b0);
      send(ops[i], av[i], bv[i], ok);
      wait_out(10, cyc);
      e = sbq.pop_front();
      checks++;
      if (!ok || result !== e.res || flags !== e.fl || out_err !== e.err) begin
        errors++;
        $display("FAIL misc_op%0d: result=%h flags=%b err=%b, want %h %b %b",
                 i, result, flags, out_err, e.res, e.fl, e.err);
      end
    end
  endtask

  task automatic test_undefined;
    logic [7:0] bad [4] = '{8'h40, 8'h48, 8'hC0, 8'h00};
    bit ok; int cyc; exp_t e;
    for (int i = 0; i < 4; i++) begin
      push(16'h0000, psr, 1'b1);
      send(bad[i], 16'hBEEF, 16'h1234, ok);
      wait_out(10, cyc);
      e = sbq.pop_front();
      checks++;
      if (!ok || cyc !== 1 || result !== e.res || flags !== e.fl || out_err !== e.err) begin
        errors++;
        $display("FAIL undef_%h: result=%h flags=%b err=%b cyc=%0d, want %h %b %b 1",
                 bad[i], result, flags, out_err, cyc, e.res, e.fl, e.err);
      end
    end
    push(16'h1234, psr, 1'b0);
    send(OP_MOV, 16'h0000, 16'h1234, ok);
    wait_out(10, cyc);
    e = sbq.pop_front();
    checks++;
    if (result !== e.res || out_err !== e.err || flags !== e.fl) begin
      errors++;
      $display("FAIL mov_after_err: result=%h err=%b, want %h %b", result, out_err, e.res, e.err);
    end
  endtask

  task automatic test_mul;
    bit ok; bit rdy_seen; int cyc; exp_t e;
    push(16'h2300, {1'b1, psr[3], psr[2], 1'b0, psr[0]}, 1'b0);
    send(OP_MUL, 16'h0123, 16'h0100, ok);
    cyc = 1; rdy_seen = 1'b0;
    while (!out_valid && cyc < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (!ok || !out_valid || cyc !== 17) begin
      errors++;
      $display("FAIL mul_latency: ov=%b cycles=%0d, want 1 17", out_valid, cyc);
    end
    checks++;
    if (rdy_seen) begin
      errors++;
      $display("FAIL mul_in_ready: in_ready rose while busy, want 0 throughout");
    end
    e = sbq.pop_front();
    checks++;
    if (result !== e.res || flags !== e.fl || out_err !== e.err) begin
      errors++;
      $display("FAIL mul_result: result=%h flags=%b, want %h %b", result, flags, e.res, e.fl);
    end
  endtask

  task automatic test_shift_hold;
    bit ok; bit stable; int cyc; exp_t e;
    push(16'hF000, psr, 1'b0);
    send(OP_ASHU, 16'h8000, 16'hFFFD, ok);
    wait_out(10, cyc);
    e = sbq.pop_front();
    checks++;
    if (!ok || result !== e.res || flags !== e.fl) begin
      errors++;
      $display("FAIL ashu: result=%h flags=%b, want %h %b", result, flags, e.res, e.fl);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    push(16'h1000, psr, 1'b0);
    send(OP_LSH, 16'h8000, 16'hFFFD, ok);
    e = sbq.pop_front();
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!out_valid || result !== e.res || flags !== e.fl || in_ready !== 1'b0) stable = 1'b0;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!ok || !stable || result !== e.res) begin
      errors++;
      $display("FAIL lsh_hold: result=%h ov=%b stable=%b, want %h 1 1", result, out_valid, stable, e.res);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add_random;
    bit ok; int cyc; exp_t e;
    logic [15:0] av, bv;
    int unsigned s;
    int ss;
    logic f;
    for (int i = 0; i < 8; i++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      if (i == 0) begin av = 16'h8000; bv = 16'h8000; end
      s  = 32'(av) + 32'(bv);
      ss = int'($signed(av)) + int'($signed(bv));
      f  = (ss > 32767) || (ss < -32768);
      push(s[15:0], {s[16], psr[3], f, (s[15:0] == 16'h0000), psr[0]}, 1'b0);
      send(OP_ADD, av, bv, ok);
      wait_out(10, cyc);
      e = sbq.pop_front();
      checks++;
      if (!ok || result !== e.res || flags !== e.fl) begin
        errors++;
        $display("FAIL add_rand%0d %h+%h: result=%h flags=%b, want %h %b",
                 i, av, bv, result, flags, e.res, e.fl);
      end
    end
  endtask

  task automatic test_reset_mid_mul;
    bit ok; int cyc; exp_t e;
    send(OP_MUL, 16'hFFFF, 16'hFFFF, ok);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (result !== 16'h0000 || flags !== 5'b00000 || out_valid !== 1'b0 ||
        out_err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_mul: result=%h flags=%b ov=%b rdy=%b, want 0000 00000 0 1",
               result, flags, out_valid, in_ready);
    end
    sbq.delete();
    psr = 5'b00000;
    @(negedge clk);
    rst_n = 1'b1;
    push(16'h0003, 5'b00000, 1'b0);
    send(OP_ADD, 16'h0001, 16'h0002, ok);
    wait_out(10, cyc);
    e = sbq.pop_front();
    checks++;
    if (!ok || cyc !== 1 || result !== e.res || flags !== e.fl) begin
      errors++;
      $display("FAIL add_after_reset: result=%h flags=%b cyc=%0d, want %h %b 1",
               result, flags, cyc, e.res, e.fl);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_add_sub_flags();
    test_back_to_back();
    test_cmpi();
    test_misc_ops();
    test_undefined();
    test_mul();
    test_shift_hold();
    test_add_random();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
